video_timing_pattern_gen: RTL and testbench
===========================================

Name: video_timing_pattern_gen

Overview:
- Parametrised raster timing and test-pattern generator for the LVDS panel path.
- Produces registered HSync/VSync/DataEnable plus RGB for the video_lvds encoder, driven from the DCM pixel clock.
- Generalises fixed-resolution counters and colour bars to configurable resolution, porches, sync polarity, colour width and runtime-selectable patterns, with frame counting and tear-free mode switching.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 24, horizontal sync width
- H_BP, 10, horizontal back porch
- V_ACTIVE, 800, active lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 3, vertical back porch
- HS_POL, 0, HSync asserted level
- VS_POL, 0, VSync asserted level
- COLOR_W, 8, bits per colour channel
- CNT_W, 12, h/v counter width; must hold H_TOTAL-1 and V_TOTAL-1
- CHECK_LOG2, 4, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, synchronous active-high reset
- en, in, 1, timing advance enable; 0 freezes counters and outputs
- mode, in, 3, pattern select; sampled only at frame start
- solid_rgb, in, 3*COLOR_W, {R,G,B} for solid mode; sampled with mode
- hsync, out, 1, horizontal sync, registered
- vsync, out, 1, vertical sync, registered
- de, out, 1, data enable, registered
- red, out, COLOR_W, red pixel
- green, out, COLOR_W, green pixel
- blue, out, COLOR_W, blue pixel
- frame_start, out, 1, one-cycle pulse aligned with first active pixel of each frame
- frame_cnt, out, 16, completed-frame counter, wraps at 0xFFFF to 0

Behaviour:
- Timing constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous.
- hcnt runs 0..H_TOTAL-1 and increments when en=1. At H_TOTAL-1, hcnt->0 and vcnt increments. vcnt wraps V_TOTAL-1 -> 0.
- Raw timing terms:
  - active_h = hcnt < H_ACTIVE
  - hs_raw = H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC
  - vertical terms are the same, using vcnt
- Registered outputs: all outputs are registered, 1-cycle latency from (hcnt,vcnt).
  - de = active_h & active_v
  - hsync = hs_raw ? HS_POL : ~HS_POL
  - vsync = vs_raw ? VS_POL : ~VS_POL; vsync is a function of vcnt only, so it changes at line start.
- Blanking: RGB is forced to 0 whenever de would be 0.
- Frame start: when hcnt==0 && vcnt==0 with en=1:
  - mode and solid_rgb are latched into mode_q and solid_q
  - frame_start is asserted on the next cycle, coincident with the de of pixel (0,0)
  - frame_cnt increments when the last pixel of a frame is counted (hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1).
- Patterns use x = hcnt, y = vcnt. All-ones per channel is written FS.
  - mode_q 0, solid: RGB = solid_q.
  - mode_q 1, 8 bars: BW = H_ACTIVE/8 (integer). Bar index = min(x/BW, 7), so the last bar absorbs the remainder. Bar order is black, blue, red, magenta, green, cyan, yellow, white; each channel is 0 or FS.
  - mode_q 2, horizontal grey ramp: R=G=B = x[COLOR_W-1:0], zero-extended if CNT_W < COLOR_W; wraps every 2^COLOR_W pixels.
  - mode_q 3, vertical grey ramp: R=G=B = y[COLOR_W-1:0].
  - mode_q 4, checkerboard: white (FS) when x[CHECK_LOG2]^y[CHECK_LOG2]=1, else black.
  - mode_q 5-7, reserved: black.
- en=0: counters, outputs, mode_q and frame_cnt all hold, and frame_start is 0. Resume continues from the held position.
- Reset:
  - rst=1 at any clock sets hcnt=vcnt=0, hsync=~HS_POL, vsync=~VS_POL, de=0, RGB=0, frame_start=0, frame_cnt=0, mode_q=0, solid_q=0.
  - A mid-frame reset aborts the frame. The first cycle after rst deasserts (with en=1) is treated as frame start, so mode is latched and frame_start pulses one cycle later.
- Mode changes: mode/solid_rgb changes mid-frame never affect the current frame (no tearing).

Optional Feature:
- Macro: VTPG_SCROLL_EN.
- Defined:
  - A 16-bit scroll offset off (0..H_ACTIVE-1) increments by 1 at each frame_cnt increment and wraps H_ACTIVE-1 -> 0.
  - Horizontal patterns (modes 1, 2, 4) use x = hcnt+off, minus H_ACTIVE if the sum is >= H_ACTIVE. Pattern logic must support this subtraction.
  - off resets to 0.
- Undefined: x = hcnt, and no offset logic is present.

Test Plan:
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, HS_POL=VS_POL=0, COLOR_W=8.
- Timing: run 2 frames, en=1 -> de high 16 clocks per line on lines 0-3 only; hsync low for clocks 18-20 of every line; vsync low for lines 5-6; frame period 192 clocks; frame_cnt 0->1->2.
- Colour bars: mode=1 -> BW=2; pixels 0-1 RGB 000000, 2-3 0000FF, 4-5 FF0000, 14-15 FFFFFF; RGB=0 during blanking.
- Tear-free switch: mode=0 with solid_rgb=123456, set mode=4 at line 2 -> lines 2-3 stay 123456; next frame is checkerboard with CHECK_LOG2=2, pixel (4,0) = FFFFFF and pixel (4,4) (wrapping bench V_ACTIVE) not checked.
- Enable hold: drop en for 10 clocks mid-line -> all outputs constant for 10 clocks; after resume the sequence continues with no lost or duplicated pixel.
- Reset: assert rst at line 2, pixel 7 -> next cycle de=0, hsync=vsync=1, RGB=0, frame_cnt=0; after release, frame_start pulses once on the 2nd cycle.
- VTPG_SCROLL_EN: mode=2, 3 frames -> pixel 0 grey value 0, 1, 2 in frames 0, 1, 2; pixel 15 in frame 1 = 0 (wrap).

Source files
------------

// File: rtl/video_timing_pattern_gen.sv
// Raster timing and test-pattern generator for the LVDS panel path.
// Optional build macro VTPG_SCROLL_EN: horizontal patterns scroll one pixel per frame.
module video_timing_pattern_gen #(
   parameter int   H_ACTIVE   = 1280,
   parameter int   H_FP       = 16,
   parameter int   H_SYNC     = 24,
   parameter int   H_BP       = 10,
   parameter int   V_ACTIVE   = 800,
   parameter int   V_FP       = 3,
   parameter int   V_SYNC     = 6,
   parameter int   V_BP       = 3,
   parameter logic HS_POL     = 1'b0,
   parameter logic VS_POL     = 1'b0,
   parameter int   COLOR_W    = 8,
   parameter int   CNT_W      = 12,
   parameter int   CHECK_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [2:0]           mode,
   input  logic [3*COLOR_W-1:0] solid_rgb,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic [COLOR_W-1:0]   red,
   output logic [COLOR_W-1:0]   green,
   output logic [COLOR_W-1:0]   blue,
   output logic                 frame_start,
   output logic [15:0]          frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BW      = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam logic [COLOR_W-1:0] FS = '1;

   logic [CNT_W-1:0]     r_hcnt;
   logic [CNT_W-1:0]     r_vcnt;
   logic [2:0]           r_mode_q;
   logic [3*COLOR_W-1:0] r_solid_q;
   logic                 r_hs;
   logic                 r_vs;
   logic                 r_de;
   logic [3*COLOR_W-1:0] r_rgb;
   logic                 r_fs;
   logic [15:0]          r_fcnt;

   logic                 w_h_last;
   logic                 w_v_last;
   logic                 w_fs;
   logic [2:0]           w_mode;
   logic [3*COLOR_W-1:0] w_solid;
   logic                 w_act_h;
   logic                 w_act_v;
   logic                 w_hs_raw;
   logic                 w_vs_raw;
   logic [CNT_W-1:0]     w_x;
   logic [CNT_W-1:0]     w_xdiv;
   logic [2:0]           w_bar;
   logic [COLOR_W-1:0]   w_gx;
   logic [COLOR_W-1:0]   w_gy;
   logic [3*COLOR_W-1:0] w_rgb;

   assign w_h_last = (r_hcnt == CNT_W'(H_TOTAL - 1));
   assign w_v_last = (r_vcnt == CNT_W'(V_TOTAL - 1));
   assign w_fs     = en && (r_hcnt == '0) && (r_vcnt == '0);

   // Pixel (0,0) must already use the mode being latched on this edge.
   assign w_mode  = w_fs ? mode : r_mode_q;
   assign w_solid = w_fs ? solid_rgb : r_solid_q;

   assign w_act_h  = (r_hcnt < CNT_W'(H_ACTIVE));
   assign w_act_v  = (r_vcnt < CNT_W'(V_ACTIVE));
   assign w_hs_raw = (r_hcnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                     (r_hcnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
   assign w_vs_raw = (r_vcnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                     (r_vcnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));

`ifdef VTPG_SCROLL_EN
   localparam int SW = ((CNT_W > 16) ? CNT_W : 16) + 1;
   logic [15:0]   r_off;
   logic [SW-1:0] w_xsum;

   assign w_xsum = SW'(r_hcnt) + SW'(r_off);
   assign w_x    = (w_xsum >= SW'(H_ACTIVE)) ?
                   CNT_W'(w_xsum - SW'(H_ACTIVE)) : CNT_W'(w_xsum);

   // Scroll offset advances once per completed frame, wrapping at H_ACTIVE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_off <= '0;
      end else if (en && w_h_last && w_v_last) begin
         r_off <= (r_off == 16'(H_ACTIVE - 1)) ? 16'd0 : r_off + 16'd1;
      end
   end
`else
   assign w_x = r_hcnt;
`endif

   assign w_xdiv = w_x / CNT_W'(BW);
   assign w_bar  = (w_xdiv > CNT_W'(7)) ? 3'd7 : w_xdiv[2:0];
   assign w_gx   = COLOR_W'(w_x);
   assign w_gy   = COLOR_W'(r_vcnt);

   // Pattern selection for the current raster position.
   always_comb begin
      w_rgb = '0;
      case (w_mode)
         3'd0: w_rgb = w_solid;
         3'd1: w_rgb = {w_bar[1] ? FS : '0,
                        w_bar[2] ? FS : '0,
                        w_bar[0] ? FS : '0};
         3'd2: w_rgb = {w_gx, w_gx, w_gx};
         3'd3: w_rgb = {w_gy, w_gy, w_gy};
         3'd4: w_rgb = (w_x[CHECK_LOG2] ^ r_vcnt[CHECK_LOG2]) ? '1 : '0;
         default: w_rgb = '0;
      endcase
   end

   // Horizontal and vertical raster counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (en) begin
         if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
         end else begin
            r_hcnt <= r_hcnt + 1'b1;
         end
      end
   end

   // Latch pattern selection only at frame start to avoid tearing.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode_q  <= '0;
         r_solid_q <= '0;
      end else if (w_fs) begin
         r_mode_q  <= mode;
         r_solid_q <= solid_rgb;
      end
   end

   // Registered sync, enable, pixel and frame outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs   <= ~HS_POL;
         r_vs   <= ~VS_POL;
         r_de   <= 1'b0;
         r_rgb  <= '0;
         r_fs   <= 1'b0;
         r_fcnt <= '0;
      end else begin
         r_fs <= w_fs;
         if (en) begin
            r_hs  <= w_hs_raw ? HS_POL : ~HS_POL;
            r_vs  <= w_vs_raw ? VS_POL : ~VS_POL;
            r_de  <= w_act_h & w_act_v;
            r_rgb <= (w_act_h & w_act_v) ? w_rgb : '0;
            if (w_h_last && w_v_last) begin
               r_fcnt <= r_fcnt + 16'd1;
            end
         end
      end
   end

   assign hsync       = r_hs;
   assign vsync       = r_vs;
   assign de          = r_de;
   assign red         = r_rgb[3*COLOR_W-1:2*COLOR_W];
   assign green       = r_rgb[2*COLOR_W-1:COLOR_W];
   assign blue        = r_rgb[COLOR_W-1:0];
   assign frame_start = r_fs;
   assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen: raster-position reference model,
// pattern vector table and hand sequences for hold, reset and mode switching.
module tb_video_timing_pattern_gen;

   localparam int HA  = 16;
   localparam int HFP = 2;
   localparam int HSW = 3;
   localparam int HBP = 3;
   localparam int VA  = 4;
   localparam int VFP = 1;
   localparam int VSW = 2;
   localparam int VBP = 1;
   localparam int CL  = 2;
   localparam int HT  = HA + HFP + HSW + HBP;
   localparam int VT  = VA + VFP + VSW + VBP;
   localparam int FT  = HT * VT;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [23:0] rgb;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   typedef struct {
      logic [2:0]  md;
      logic [23:0] sd;
      int          x;
      int          y;
      logic [23:0] rgb;
   } vec_t;

   localparam exp_t RST_EXP = '{hs: 1'b1, vs: 1'b1, de: 1'b0,
                                rgb: 24'h0, fs: 1'b0, fc: 16'h0};

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [2:0]  mode;
   logic [23:0] solid;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        frame_start;
   logic [15:0] frame_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   video_timing_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .CNT_W(12),
      .CHECK_LOG2(CL)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
      .hsync(hsync), .vsync(vsync), .de(de),
      .red(red), .green(green), .blue(blue),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   function automatic logic [23:0] bar_rgb(int b);
      case (b)
         0: return 24'h000000;
         1: return 24'h0000FF;
         2: return 24'hFF0000;
         3: return 24'hFF00FF;
         4: return 24'h00FF00;
         5: return 24'h00FFFF;
         6: return 24'hFFFF00;
         default: return 24'hFFFFFF;
      endcase
   endfunction

   // Expected outputs after counting absolute position pos since reset.
   function automatic exp_t model(int pos, logic [2:0] md, logic [23:0] sd);
      exp_t e;
      int h, v, fr, x, b;
      h  = pos % HT;
      v  = (pos / HT) % VT;
      fr = pos / FT;
      x  = h;
`ifdef VTPG_SCROLL_EN
      x = (h + fr % HA) % HA;
`endif
      e.de  = (h < HA) && (v < VA);
      e.hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? 1'b0 : 1'b1;
      e.vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? 1'b0 : 1'b1;
      e.fs  = (pos % FT == 0);
      e.fc  = 16'((pos + 1) / FT);
      e.rgb = 24'h0;
      if (e.de) begin
         case (md)
            3'd0: e.rgb = sd;
            3'd1: begin
               b = x / (HA / 8);
               if (b > 7) b = 7;
               e.rgb = bar_rgb(b);
            end
            3'd2: e.rgb = {3{8'(x)}};
            3'd3: e.rgb = {3{8'(v)}};
            3'd4: e.rgb = (((x >> CL) ^ (v >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
            default: e.rgb = 24'h0;
         endcase
      end
      return e;
   endfunction

   int          m_pos = 0;
   int          m_x = 0;
   int          m_y = 0;
   logic [2:0]  m_mode = 3'd0;
   logic [23:0] m_solid = 24'h0;
   exp_t        m_exp = RST_EXP;

   always @(posedge clk) begin
      if (rst) begin
         m_pos   <= 0;
         m_mode  <= 3'd0;
         m_solid <= 24'h0;
         m_exp   <= RST_EXP;
      end else if (en) begin
         if (m_pos % FT == 0) begin
            m_mode  <= mode;
            m_solid <= solid;
            m_exp   <= model(m_pos, mode, solid);
         end else begin
            m_exp   <= model(m_pos, m_mode, m_solid);
         end
         m_x   <= m_pos % HT;
         m_y   <= (m_pos / HT) % VT;
         m_pos <= m_pos + 1;
      end else begin
         m_exp.fs <= 1'b0;
      end
   end

   logic [23:0] cap [VA][HA];

   function automatic exp_t dut_vec();
      return '{hs: hsync, vs: vsync, de: de, rgb: {red, green, blue},
               fs: frame_start, fc: frame_cnt};
   endfunction

   task automatic tick();
      exp_t d;
      @(posedge clk);
      @(negedge clk);
      d = dut_vec();
      n_cmp++;
      if (d !== m_exp) begin
         n_err++;
         $display("FAIL cycle t=%0t dut=%h model=%h", $time, d, m_exp);
      end
      if (m_exp.de) cap[m_y][m_x] = {red, green, blue};
   endtask

   task automatic cmp(input string nm, input logic [47:0] act,
                      input logic [47:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", nm, act, req);
      end
   endtask

   task automatic seek(input int target);
      int k;
      k = 0;
      while (m_pos % FT != target && k <= FT) begin
         tick();
         k++;
      end
      if (m_pos % FT != target) begin
         n_cmp++;
         n_err++;
         $display("FAIL seek got=%0d want=%0d", m_pos % FT, target);
      end
   endtask

   task automatic run_frame();
      seek(0);
      repeat (FT) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      vec_t vt [18];
      int   c_de, c_hs, c_vs, c_fs, t_fs0, t_fs1;
      exp_t snap;

      rst   = 1'b1;
      en    = 1'b0;
      mode  = 3'd0;
      solid = 24'h0;
      tick();
      tick();
      cmp("rst_state", 48'(dut_vec()), 48'(RST_EXP));

      // Two-frame timing run from reset.
      rst  = 1'b0;
      en   = 1'b1;
      mode = 3'd1;
      c_de = 0; c_hs = 0; c_vs = 0; c_fs = 0; t_fs0 = 0; t_fs1 = 0;
      for (int i = 0; i < 2 * FT; i++) begin
         tick();
         if (de) c_de++;
         if (!hsync) c_hs++;
         if (!vsync) c_vs++;
         if (frame_start) begin
            if (c_fs == 0) t_fs0 = i;
            else t_fs1 = i;
            c_fs++;
         end
      end
      cmp("de_count", 48'(c_de), 48'(2 * VA * HA));
      cmp("hs_low", 48'(c_hs), 48'(2 * VT * HSW));
      cmp("vs_low", 48'(c_vs), 48'(2 * VSW * HT));
      cmp("fs_count", 48'(c_fs), 48'd2);
      cmp("fs_period", 48'(t_fs1 - t_fs0), 48'(FT));
      cmp("frame_cnt2", 48'(frame_cnt), 48'd2);

`ifndef VTPG_SCROLL_EN
      vt[0]  = '{3'd1, 24'h0, 0, 0, 24'h000000};
      vt[1]  = '{3'd1, 24'h0, 1, 0, 24'h000000};
      vt[2]  = '{3'd1, 24'h0, 2, 0, 24'h0000FF};
      vt[3]  = '{3'd1, 24'h0, 3, 1, 24'h0000FF};
      vt[4]  = '{3'd1, 24'h0, 4, 0, 24'hFF0000};
      vt[5]  = '{3'd1, 24'h0, 5, 2, 24'hFF0000};
      vt[6]  = '{3'd1, 24'h0, 6, 0, 24'hFF00FF};
      vt[7]  = '{3'd1, 24'h0, 8, 0, 24'h00FF00};
      vt[8]  = '{3'd1, 24'h0, 12, 0, 24'hFFFF00};
      vt[9]  = '{3'd1, 24'h0, 15, 3, 24'hFFFFFF};
      vt[10] = '{3'd2, 24'h0, 5, 1, 24'h050505};
      vt[11] = '{3'd2, 24'h0, 15, 0, 24'h0F0F0F};
      vt[12] = '{3'd3, 24'h0, 3, 2, 24'h020202};
      vt[13] = '{3'd4, 24'h0, 4, 0, 24'hFFFFFF};
      vt[14] = '{3'd4, 24'h0, 8, 3, 24'h000000};
      vt[15] = '{3'd4, 24'h0, 12, 2, 24'hFFFFFF};
      vt[16] = '{3'd0, 24'hABCDEF, 7, 3, 24'hABCDEF};
      vt[17] = '{3'd6, 24'hABCDEF, 9, 1, 24'h000000};
      for (int i = 0; i < 18; i++) begin
         if (i == 0 || vt[i].md != vt[i-1].md || vt[i].sd != vt[i-1].sd) begin
            mode  = vt[i].md;
            solid = vt[i].sd;
            run_frame();
         end
         cmp($sformatf("vec%0d", i), 48'(cap[vt[i].y][vt[i].x]), 48'(vt[i].rgb));
      end

      // Mode switch mid-frame must wait for the next frame.
      mode  = 3'd0;
      solid = 24'h123456;
      seek(0);
      seek(2 * HT);
      mode = 3'd4;
      repeat (FT - 2 * HT) tick();
      cmp("tear_l2p0", 48'(cap[2][0]), 48'h123456);
      cmp("tear_l2p4", 48'(cap[2][4]), 48'h123456);
      cmp("tear_l3p15", 48'(cap[3][15]), 48'h123456);
      repeat (FT) tick();
      cmp("next_p4_0", 48'(cap[0][4]), 48'hFFFFFF);
      cmp("next_p0_0", 48'(cap[0][0]), 48'h000000);
`endif

      // Enable hold mid-line.
      mode = 3'd2;
      seek(HT + 5);
      snap    = m_exp;
      snap.fs = 1'b0;
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cmp($sformatf("hold%0d", i), 48'(dut_vec()), 48'(snap));
      end
      en = 1'b1;
      repeat (FT) tick();

      // Mid-frame reset at line 2, pixel 7.
      seek(2 * HT + 7);
      rst = 1'b1;
      tick();
      cmp("rst_de", 48'(de), 48'd0);
      cmp("rst_hs_vs", 48'({hsync, vsync}), 48'd3);
      cmp("rst_rgb", 48'({red, green, blue}), 48'd0);
      cmp("rst_fcnt", 48'(frame_cnt), 48'd0);
      rst = 1'b0;
      tick();
      cmp("rel_fs1", 48'(frame_start), 48'd1);
      tick();
      cmp("rel_fs2", 48'(frame_start), 48'd0);

`ifdef VTPG_SCROLL_EN
      mode = 3'd2;
      do_reset();
      for (int f = 0; f < 3; f++) begin
         repeat (FT) tick();
         cmp($sformatf("scroll_f%0d_p0", f), 48'(cap[0][0]), 48'({3{8'(f)}}));
         if (f == 1) cmp("scroll_f1_p15", 48'(cap[0][15]), 48'd0);
      end
`endif

      // Randomised enable, mode and occasional reset traffic.
      for (int i = 0; i < 4000; i++) begin
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 99) == 0) begin
            mode  = 3'($urandom_range(0, 7));
            solid = 24'($urandom);
         end
         if ($urandom_range(0, 999) == 0) do_reset();
         else tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
